// File: rtl/fw_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: register address, scoreboard
// entry and the fw_sel width helper.
package fw_scoreboard_pkg;

    localparam int REG_AW                   = 5;
    localparam int DEFAULT_DEPTH            = 2;
    localparam int DEFAULT_LOAD_READY_STAGE = 2;

    typedef logic [REG_AW-1:0] regaddr_t;

    typedef struct packed {
        logic     valid;
        logic     is_load;
        regaddr_t rd_addr;
    } sb_entry_t;

    // fw_sel needs to encode 0 (register file) plus stages 1..depth.
    function automatic int fw_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fw_port_resolve.sv
// Resolves one source-register read port against the in-flight scoreboard:
// picks the youngest matching stage and flags it when not yet forwardable.
module fw_port_resolve
    import fw_scoreboard_pkg::*;
#(
    parameter int DEPTH            = DEFAULT_DEPTH,
    parameter int LOAD_READY_STAGE = DEFAULT_LOAD_READY_STAGE,
    parameter int SEL_W            = fw_sel_width(DEPTH)
) (
    input  regaddr_t              i_src_addr,
    input  sb_entry_t [DEPTH:1]   i_stages,
    output logic [SEL_W-1:0]      o_fw_sel,
    output logic                  o_hazard
);

    always_comb begin
        o_fw_sel = '0;
        o_hazard = 1'b0;
        // Walk from oldest to youngest so the youngest match overwrites.
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_stages[k].valid && (i_stages[k].rd_addr == i_src_addr) &&
                (i_src_addr != '0)) begin
                o_fw_sel = SEL_W'(k);
                o_hazard = i_stages[k].is_load && (k < LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/fw_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination registers per stage,
// selects forwarding sources and raises load-use stall with a stall counter.
module fw_scoreboard
    import fw_scoreboard_pkg::*;
#(
    parameter int NUM_RPORTS       = 2,
    parameter int DEPTH            = DEFAULT_DEPTH,
    parameter int LOAD_READY_STAGE = DEFAULT_LOAD_READY_STAGE
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              advance,
    input  logic                                              flush,
    input  logic                                              issue_valid,
    input  logic                                              issue_rd_we,
    input  logic                                              issue_is_load,
    input  regaddr_t                                          issue_rd_addr,
    input  regaddr_t [NUM_RPORTS-1:0]                         src_addr,
    output logic [NUM_RPORTS-1:0][fw_sel_width(DEPTH)-1:0]    fw_sel,
    output logic                                              stall,
    output logic [15:0]                                       stall_count
);

    localparam int SEL_W = fw_sel_width(DEPTH);

    sb_entry_t [DEPTH:1]                 r_stage;
    logic [15:0]                         r_stall_count;
    logic [NUM_RPORTS-1:0][SEL_W-1:0]    w_sel;
    logic [NUM_RPORTS-1:0]               w_hazard;
    logic                                w_stall;
    logic                                w_insert;
    sb_entry_t                           w_issue_entry;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
        fw_port_resolve #(
            .DEPTH            (DEPTH),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_resolve (
            .i_src_addr (src_addr[p]),
            .i_stages   (r_stage),
            .o_fw_sel   (w_sel[p]),
            .o_hazard   (w_hazard[p])
        );
    end

    // Outputs are forced quiet while reset is held so nothing stale leaks out.
    assign w_stall = !rst && issue_valid && (|w_hazard);
    assign stall   = w_stall;
    assign fw_sel  = rst ? '0 : w_sel;

    // r0 writes and killed/stalled issues enter stage 1 as bubbles.
    assign w_insert = issue_valid && issue_rd_we && !w_stall && !flush &&
                      (issue_rd_addr != '0);

    always_comb begin
        w_issue_entry         = '0;
        w_issue_entry.valid   = w_insert;
        w_issue_entry.is_load = issue_is_load;
        w_issue_entry.rd_addr = issue_rd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage       <= '0;
            r_stall_count <= '0;
        end else if (advance) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_stage[k] <= r_stage[k-1];
            end
            r_stage[1] <= w_insert ? w_issue_entry : '0;
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fw_scoreboard.sv
// Directed bench for fw_scoreboard with hand-computed expectations.
module tb_fw_scoreboard;
    import fw_scoreboard_pkg::*;

    logic                clk;
    logic                rst;
    logic                advance;
    logic                flush;
    logic                issue_valid;
    logic                issue_rd_we;
    logic                issue_is_load;
    regaddr_t            issue_rd_addr;
    regaddr_t [1:0]      src_addr;
    logic [1:0][1:0]     fw_sel;
    logic                stall;
    logic [15:0]         stall_count;

    int n_checks = 0;
    int n_errors = 0;

    fw_scoreboard #(
        .NUM_RPORTS       (2),
        .DEPTH            (2),
        .LOAD_READY_STAGE (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .advance       (advance),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rd_we   (issue_rd_we),
        .issue_is_load (issue_is_load),
        .issue_rd_addr (issue_rd_addr),
        .src_addr      (src_addr),
        .fw_sel        (fw_sel),
        .stall         (stall),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Set the instruction presented at issue.
    task automatic issue(input logic v, input logic we, input logic ld,
                         input logic [4:0] rd, input logic [4:0] s0, input logic [4:0] s1);
        issue_valid   = v;
        issue_rd_we   = we;
        issue_is_load = ld;
        issue_rd_addr = rd;
        src_addr[0]   = s0;
        src_addr[1]   = s1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drain();
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        advance = 1'b1;
        flush = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4);
        sample();
        chk("rst_fw0", fw_sel[0], 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_count, 0);
        step();
        rst = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4);
        sample();
        chk("post_rst_fw0", fw_sel[0], 0);

        // ALU add r3, then consumer of r3.
        issue(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        sample();
        chk("alu_prod_stall", stall, 0);
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd1);
        sample();
        chk("alu_fw_s1", fw_sel[0], 1);
        chk("alu_fw_p1", fw_sel[1], 0);
        chk("alu_stall", stall, 0);
        step();
        sample();
        chk("alu_fw_s2", fw_sel[0], 2);
        drain();
        sample();
        chk("drained_fw", fw_sel[0], 0);

        // Load r5, then use of r5: one stall cycle then forward from stage 2.
        issue(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0);
        sample();
        chk("ld_use_stall", stall, 1);
        chk("ld_use_fw", fw_sel[0], 1);
        step();
        sample();
        chk("ld_use_stall_clr", stall, 0);
        chk("ld_use_fw2", fw_sel[0], 2);
        chk("ld_use_cnt", stall_count, 1);
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd6);
        sample();
        chk("bubble_fw0", fw_sel[0], 0);
        chk("after_stall_fw1", fw_sel[1], 1);
        drain();

        // Two writers of r7: youngest (stage 1) wins.
        issue(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
        step();
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7);
        sample();
        chk("youngest_p0", fw_sel[0], 1);
        chk("youngest_p1", fw_sel[1], 1);
        chk("youngest_stall", stall, 0);
        drain();

        // ALU r8 in stage 2, load r8 in stage 1: youngest is not ready.
        issue(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
        sample();
        chk("young_load_stall", stall, 1);
        chk("young_load_fw", fw_sel[1], 1);
        issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
        sample();
        chk("no_issue_no_stall", stall, 0);
        drain();

        // r0 writer never forwards.
        issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        sample();
        chk("r0_fw", fw_sel[0], 0);
        chk("r0_stall", stall, 0);
        drain();

        // Flushed load enters as a bubble.
        flush = 1'b1;
        issue(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
        step();
        flush = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0);
        sample();
        chk("flush_fw", fw_sel[0], 0);
        chk("flush_stall", stall, 0);
        drain();

        // Load-use hazard held for 3 cycles with advance=0.
        issue(1'b1, 1'b1, 1'b1, 5'd11, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0);
        advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("hold_stall", stall, 1);
            chk("hold_fw", fw_sel[0], 1);
            chk("hold_cnt", stall_count, 1);
            step();
        end
        advance = 1'b1;
        step();
        sample();
        chk("hold_release_cnt", stall_count, 2);
        chk("hold_release_stall", stall, 0);
        chk("hold_release_fw", fw_sel[0], 2);
        drain();

        // Reset while stalled on load r9.
        issue(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd9);
        sample();
        chk("r9_stall", stall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_fw0", fw_sel[0], 0);
        chk("rst_mid_fw1", fw_sel[1], 0);
        chk("rst_mid_cnt", stall_count, 0);
        step();
        sample();
        chk("rst_after_stall", stall, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
